vector_unpacker: RTL and testbench



---
 rtl/vector_pkg.sv | 26 ++
 rtl/vector_if.sv | 25 ++
 rtl/vector_lane_mux.sv | 45 ++++
 rtl/vector_unpacker.sv | 144 ++++++++++++++
 tb/tb_vector_unpacker.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vector_pkg.sv
// vector_pkg
// Shared definitions for the vector stream endpoints (unpacker now, packer later).
//   idx_w / lane_w : width helpers, never narrower than one bit
//   state_t        : unpacker control states
//   lane_base      : bit offset of a lane inside a flattened multi-lane bus
package vector_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } state_t;

  function automatic int idx_w(input int vector_length);
    return (vector_length > 1) ? $clog2(vector_length) : 1;
  endfunction

  function automatic int lane_w(input int numbers);
    return (numbers > 1) ? $clog2(numbers) : 1;
  endfunction

  // Lane L occupies [lane_base(L, W) +: W] of a flattened bus of W-bit lanes.
  function automatic int lane_base(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/vector_if.sv
// vector_if
// Multi-lane beat stream: NUMBERS elements plus their indices per beat.
//   valid/ready : handshake, transfer on valid && ready
//   data        : NUMBERS x NUMBER_WIDTH, lane 0 in the low bits
//   index       : NUMBERS x IDX_W, lane 0 in the low bits
//   last        : final beat of the frame
//   keep        : valid lanes minus 1, meaningful only when last=1
interface vector_if #(
  parameter int NUMBERS       = 4,
  parameter int NUMBER_WIDTH  = 32,
  parameter int VECTOR_LENGTH = 32
) ();
  localparam int IDX_W  = vector_pkg::idx_w(VECTOR_LENGTH);
  localparam int LANE_W = vector_pkg::lane_w(NUMBERS);

  logic                            valid;
  logic                            ready;
  logic [NUMBERS*NUMBER_WIDTH-1:0] data;
  logic [NUMBERS*IDX_W-1:0]        index;
  logic                            last;
  logic [LANE_W-1:0]               keep;

  modport master (output valid, data, index, last, keep, input ready);
  modport slave  (input valid, data, index, last, keep, output ready);
endinterface

// File: rtl/vector_lane_mux.sv
// vector_lane_mux
// Combinational NUMBERS:1 selection of one element and its index.
//   data_in/index_in   : flattened held beat
//   lane               : lane to present
//   data_out/index_out : selected element (zero if lane is out of range)
module vector_lane_mux
  import vector_pkg::*;
#(
  parameter int NUMBERS      = 4,
  parameter int NUMBER_WIDTH = 32,
  parameter int IDX_W        = 5,
  parameter int LANE_W       = 2
) (
  input  logic [NUMBERS*NUMBER_WIDTH-1:0] data_in,
  input  logic [NUMBERS*IDX_W-1:0]        index_in,
  input  logic [LANE_W-1:0]               lane,
  output logic [NUMBER_WIDTH-1:0]         data_out,
  output logic [IDX_W-1:0]                index_out
);

  logic [NUMBER_WIDTH-1:0] data_lanes  [NUMBERS];
  logic [IDX_W-1:0]        index_lanes [NUMBERS];

  genvar gi;
  generate
    for (gi = 0; gi < NUMBERS; gi++) begin : g_lane
      assign data_lanes[gi]  = data_in[lane_base(gi, NUMBER_WIDTH) +: NUMBER_WIDTH];
      assign index_lanes[gi] = index_in[lane_base(gi, IDX_W) +: IDX_W];
    end
  endgenerate

  // Compare-and-select keeps non-power-of-2 lane counts safe: unused
  // lane codes simply produce zero.
  always_comb begin
    data_out  = '0;
    index_out = '0;
    for (int i = 0; i < NUMBERS; i++) begin
      if (lane == LANE_W'(i)) begin
        data_out  = data_lanes[i];
        index_out = index_lanes[i];
      end
    end
  end

endmodule

// File: rtl/vector_unpacker.sv
// vector_unpacker
// Serialises multi-lane beats into a one-element-per-cycle stream, keeping
// element order, frame boundaries and partial final beats.
//   clk, rst_n : clock, synchronous active-low reset
//   s_vec      : input beat stream (slave side)
//   m_valid/m_ready/m_data/m_index/m_last : scalar output stream
// Format tags (FLOAT, MANTISSA, EXPONENT, SIGNED) describe the element
// encoding only; no arithmetic is done on the data.
module vector_unpacker
  import vector_pkg::*;
#(
  parameter  int NUMBERS       = 4,
  parameter  int NUMBER_WIDTH  = 32,
  parameter  int VECTOR_LENGTH = 32,
  parameter  int FLOAT         = 1,
  parameter  int MANTISSA      = 23,
  parameter  int EXPONENT      = 8,
  parameter  int SIGNED        = 1,
  localparam int IDX_W         = idx_w(VECTOR_LENGTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  vector_if.slave                 s_vec,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [NUMBER_WIDTH-1:0] m_data,
  output logic [IDX_W-1:0]        m_index,
  output logic                    m_last
);

  localparam int                LANE_W   = lane_w(NUMBERS);
  localparam logic [LANE_W-1:0] MAX_LANE = LANE_W'(NUMBERS - 1);

  // Reject parameter sets that cannot describe a sensible stream.
  generate
    if (NUMBERS < 2) begin : g_bad_numbers
      $error("vector_unpacker: NUMBERS must be at least 2");
    end
    if (FLOAT != 0 && (SIGNED == 0 || 1 + EXPONENT + MANTISSA != NUMBER_WIDTH)) begin : g_bad_format
      $error("vector_unpacker: float format tags do not match NUMBER_WIDTH");
    end
  endgenerate

  state_t                          state_reg, state_next;
  logic [LANE_W-1:0]               lane_reg, lane_next;
  logic [LANE_W-1:0]               top_reg, top_next;
  logic [NUMBERS*NUMBER_WIDTH-1:0] data_reg, data_next;
  logic [NUMBERS*IDX_W-1:0]        index_reg, index_next;
  logic                            last_reg, last_next;

  logic              lane_done;
  logic              in_ready;
  logic              load;
  logic [LANE_W-1:0] beat_top;

  assign lane_done = (lane_reg == top_reg);

  // Ready is combinational from m_ready so the next beat can be loaded on
  // the same edge that retires the final lane of the current one.
  assign in_ready    = (state_reg == EMPTY) || (lane_done && m_ready);
  assign s_vec.ready = in_ready;
  assign load        = s_vec.valid && in_ready;

  // Non-final beats are always full; keep beyond the lane count saturates.
  always_comb begin
    beat_top = MAX_LANE;
    if (s_vec.last) begin
      beat_top = (s_vec.keep > MAX_LANE) ? MAX_LANE : s_vec.keep;
    end
  end

  always_comb begin
    state_next = state_reg;
    lane_next  = lane_reg;
    top_next   = top_reg;
    data_next  = data_reg;
    index_next = index_reg;
    last_next  = last_reg;
    m_valid    = 1'b0;

    case (state_reg)
      EMPTY: begin
        m_valid = 1'b0;
      end
      HOLD: begin
        m_valid = 1'b1;
        if (m_ready) begin
          if (!lane_done) begin
            lane_next = lane_reg + 1'b1;
          end else begin
            state_next = EMPTY;
          end
        end
      end
      default: begin
        state_next = EMPTY;
      end
    endcase

    // A new beat overrides the retire-to-EMPTY decision above.
    if (load) begin
      state_next = HOLD;
      lane_next  = '0;
      top_next   = beat_top;
      data_next  = s_vec.data;
      index_next = s_vec.index;
      last_next  = s_vec.last;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= EMPTY;
      lane_reg  <= '0;
      top_reg   <= '0;
      data_reg  <= '0;
      index_reg <= '0;
      last_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      lane_reg  <= lane_next;
      top_reg   <= top_next;
      data_reg  <= data_next;
      index_reg <= index_next;
      last_reg  <= last_next;
    end
  end

  vector_lane_mux #(
    .NUMBERS     (NUMBERS),
    .NUMBER_WIDTH(NUMBER_WIDTH),
    .IDX_W       (IDX_W),
    .LANE_W      (LANE_W)
  ) u_lane_mux (
    .data_in  (data_reg),
    .index_in (index_reg),
    .lane     (lane_reg),
    .data_out (m_data),
    .index_out(m_index)
  );

  assign m_last = (state_reg == HOLD) && last_reg && lane_done;

endmodule

// File: tb/tb_vector_unpacker.sv
// tb_vector_unpacker
// Directed table vectors, hand-written corner sequences and a randomized
// scoreboard run for vector_unpacker with NUMBERS=4.
module tb_vector_unpacker;
  localparam int NUMBERS = 4;
  localparam int NW      = 32;
  localparam int VL      = 32;
  localparam int IDX_W   = 5;
  localparam int LANE_W  = 2;
  localparam int NBEATS  = 4000;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             m_valid, m_ready, m_last;
  logic [NW-1:0]    m_data;
  logic [IDX_W-1:0] m_index;

  vector_if #(.NUMBERS(NUMBERS), .NUMBER_WIDTH(NW), .VECTOR_LENGTH(VL)) vec ();

  vector_unpacker #(.NUMBERS(NUMBERS), .NUMBER_WIDTH(NW), .VECTOR_LENGTH(VL)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .s_vec  (vec),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data (m_data),
    .m_index(m_index),
    .m_last (m_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NUMBERS*NW-1:0]    data;
    logic [NUMBERS*IDX_W-1:0] index;
    logic                     last;
    logic [LANE_W-1:0]        keep;
    int                       n_exp;
  } vec_t;

  typedef struct packed {
    logic [NW-1:0]    d;
    logic [IDX_W-1:0] ix;
    logic             l;
  } elem_t;

  int    checks = 0;
  int    failures = 0;
  vec_t  tbl[5];
  elem_t exp_q[$];
  elem_t got_q[$];
  logic  mon_en = 1'b0;
  logic  rand_done = 1'b0;
  int    unstable = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_beat(input vec_t e);
    vec.data  = e.data;
    vec.index = e.index;
    vec.last  = e.last;
    vec.keep  = e.keep;
    vec.valid = 1'b1;
  endtask

  // Offer one beat with m_ready=1 and check every emitted element.
  task automatic run_entry(input vec_t e, input string tag);
    @(posedge clk); #1;
    drive_beat(e);
    m_ready = 1'b1;
    #1 check({tag, "_ready_offer"}, vec.ready, 1);
    @(posedge clk); #1;
    vec.valid = 1'b0;
    for (int k = 0; k < e.n_exp; k++) begin
      check({tag, "_valid"}, m_valid, 1);
      check({tag, "_data"}, m_data, e.data[k*NW +: NW]);
      check({tag, "_index"}, m_index, e.index[k*IDX_W +: IDX_W]);
      check({tag, "_last"}, m_last, (e.last && k == e.n_exp - 1));
      check({tag, "_ready"}, vec.ready, (k == e.n_exp - 1));
      @(posedge clk); #1;
    end
    check({tag, "_idle_after"}, m_valid, 0);
  endtask

  // Beat b of a sequence: lane l carries value 4b+l+1 and index 4b+l.
  function automatic vec_t mk_seq_beat(input int b, input logic last);
    vec_t r;
    for (int l = 0; l < NUMBERS; l++) begin
      r.data[l*NW +: NW]       = NW'(b*NUMBERS + l + 1);
      r.index[l*IDX_W +: IDX_W] = IDX_W'(b*NUMBERS + l);
    end
    r.last  = last;
    r.keep  = LANE_W'(NUMBERS - 1);
    r.n_exp = NUMBERS;
    return r;
  endfunction

  // Observer for the random run: records handshakes, checks hold stability.
  initial begin
    logic  stall_prev;
    elem_t held;
    stall_prev = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (mon_en && rst_n) begin
        if (stall_prev && (!m_valid || {m_data, m_index, m_last} != held)) unstable++;
        if (m_valid && m_ready) got_q.push_back({m_data, m_index, m_last});
        stall_prev = m_valid && !m_ready;
        held = {m_data, m_index, m_last};
      end
    end
  end

  initial begin
    vec_t e;
    vec_t alt;
    int   bi;
    logic hs;
    int   timeouts;
    int   lasts_exp;
    int   lasts_got;
    int   mism;
    int   w;

    vec.valid = 1'b0;
    vec.data  = '0;
    vec.index = '0;
    vec.last  = 1'b0;
    vec.keep  = '0;
    m_ready   = 1'b0;

    tbl[0] = '{data: {32'd4, 32'd3, 32'd2, 32'd1}, index: {5'd7, 5'd5, 5'd2, 5'd0},
               last: 1'b1, keep: 2'd3, n_exp: 4};
    tbl[1] = '{data: {32'd99, 32'd98, 32'd20, 32'd10}, index: {5'd31, 5'd30, 5'd9, 5'd3},
               last: 1'b1, keep: 2'd1, n_exp: 2};
    tbl[2] = '{data: {32'hdead, 32'hbeef, 32'h1234, 32'h5678}, index: {5'd1, 5'd2, 5'd3, 5'd4},
               last: 1'b0, keep: 2'd1, n_exp: 4};
    tbl[3] = '{data: {32'd0, 32'd0, 32'd0, 32'hcafe}, index: {5'd0, 5'd0, 5'd0, 5'd17},
               last: 1'b1, keep: 2'd0, n_exp: 1};
    tbl[4] = '{data: {32'd7, 32'd300, 32'd200, 32'd100}, index: {5'd6, 5'd12, 5'd11, 5'd10},
               last: 1'b1, keep: 2'd2, n_exp: 3};

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_index", m_index, 0);
    check("rst_m_last", m_last, 0);
    @(posedge clk); #1;
    check("rst_ready", vec.ready, 1);

    // Table-driven beats
    for (int i = 0; i < 5; i++) begin
      run_entry(tbl[i], $sformatf("tbl%0d", i));
    end

    // Back-to-back: three full beats, valid held high, no bubbles
    m_ready = 1'b1;
    bi = 0;
    @(posedge clk); #1;
    drive_beat(mk_seq_beat(0, 1'b0));
    for (int c = 0; c <= 12; c++) begin
      #1;
      check($sformatf("b2b_ready_c%0d", c), vec.ready, (c % 4 == 0));
      if (c >= 1) begin
        check($sformatf("b2b_valid_c%0d", c), m_valid, 1);
        check($sformatf("b2b_data_c%0d", c), m_data, c);
        check($sformatf("b2b_index_c%0d", c), m_index, c - 1);
        check($sformatf("b2b_last_c%0d", c), m_last, (c == 12));
      end
      hs = vec.valid && vec.ready;
      @(posedge clk); #1;
      if (hs) begin
        bi++;
        if (bi < 3) drive_beat(mk_seq_beat(bi, bi == 2));
        else vec.valid = 1'b0;
      end
    end
    check("b2b_beats_taken", bi, 3);
    check("b2b_idle_after", m_valid, 0);

    // Backpressure on lane 2, with a competing beat offered during the stall
    e   = '{data: {32'd40, 32'd30, 32'd20, 32'd10}, index: {5'd4, 5'd3, 5'd2, 5'd1},
            last: 1'b1, keep: 2'd3, n_exp: 4};
    alt = '{data: {32'd8, 32'd8, 32'd8, 32'd8}, index: {5'd8, 5'd8, 5'd8, 5'd8},
            last: 1'b1, keep: 2'd3, n_exp: 4};
    @(posedge clk); #1;
    drive_beat(e);
    m_ready = 1'b1;
    @(posedge clk); #1;
    vec.valid = 1'b0;
    check("bp_lane0", m_data, 10);
    @(posedge clk); #1;
    check("bp_lane1", m_data, 20);
    @(posedge clk); #1;
    m_ready = 1'b0;
    drive_beat(alt);
    for (int s = 0; s < 3; s++) begin
      #1;
      check($sformatf("bp_stall%0d_valid", s), m_valid, 1);
      check($sformatf("bp_stall%0d_data", s), m_data, 30);
      check($sformatf("bp_stall%0d_index", s), m_index, 3);
      check($sformatf("bp_stall%0d_last", s), m_last, 0);
      check($sformatf("bp_stall%0d_ready", s), vec.ready, 0);
      @(posedge clk); #1;
    end
    vec.valid = 1'b0;
    m_ready = 1'b1;
    #1 check("bp_resume_lane2", m_data, 30);
    @(posedge clk); #1;
    check("bp_lane3_data", m_data, 40);
    check("bp_lane3_last", m_last, 1);
    @(posedge clk); #1;
    check("bp_idle_after", m_valid, 0);

    // Reset in the middle of a beat
    @(posedge clk); #1;
    drive_beat(tbl[0]);
    m_ready = 1'b1;
    @(posedge clk); #1;
    vec.valid = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_lane1", m_data, 2);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_valid", m_valid, 0);
    check("mid_rst_ready", vec.ready, 1);
    check("mid_rst_last", m_last, 0);
    rst_n = 1'b1;
    run_entry(tbl[1], "post_rst");

    // Randomized valid/ready against a queue model
    mon_en = 1'b1;
    lasts_exp = 0;
    timeouts = 0;
    fork
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          m_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join_none
    for (int b = 0; b < NBEATS; b++) begin
      vec_t r;
      int   n;
      int   idle;
      for (int l = 0; l < NUMBERS; l++) begin
        r.data[l*NW +: NW]       = $urandom;
        r.index[l*IDX_W +: IDX_W] = IDX_W'($urandom_range(0, VL - 1));
      end
      r.last = ($urandom_range(0, 3) == 0);
      r.keep = LANE_W'($urandom_range(0, NUMBERS - 1));
      n = r.last ? int'(r.keep) + 1 : NUMBERS;
      for (int l = 0; l < n; l++) begin
        exp_q.push_back({r.data[l*NW +: NW], r.index[l*IDX_W +: IDX_W], (r.last && l == n - 1)});
      end
      if (r.last) lasts_exp++;
      idle = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
      vec.valid = 1'b0;
      repeat (idle) begin
        @(posedge clk); #1;
      end
      drive_beat(r);
      w = 0;
      do begin
        @(negedge clk);
        hs = vec.valid && vec.ready;
        @(posedge clk); #1;
        w++;
      end while (!hs && w < 200);
      if (!hs) begin
        timeouts++;
        break;
      end
    end
    vec.valid = 1'b0;
    w = 0;
    while (got_q.size() < exp_q.size() && w < 2000) begin
      @(posedge clk); #1;
      w++;
    end
    repeat (4) @(posedge clk);
    rand_done = 1'b1;
    mon_en = 1'b0;

    lasts_got = 0;
    mism = 0;
    foreach (got_q[i]) begin
      if (got_q[i].l) lasts_got++;
      if (i < exp_q.size() && got_q[i] != exp_q[i]) mism++;
    end
    check("rand_accept_timeouts", timeouts, 0);
    check("rand_elem_count", got_q.size(), exp_q.size());
    check("rand_last_count", lasts_got, lasts_exp);
    check("rand_elem_mismatches", mism, 0);
    check("rand_hold_unstable", unstable, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
